// File: rtl/sc_mm_pkg.sv
// Shared types and constants for the stochastic matrix-multiply job sequencer.
//   state_t     : sequencer states (IDLE, LOAD, WARMUP, RUN, DONE)
//   stream_len  : stochastic stream length in cycles, 1 << log2 length
//   PERF_CNT_W  : width of the optional performance counters
package sc_mm_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WARMUP = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int PERF_CNT_W = 32;

  function automatic int stream_len(input int log2_len);
    return 1 << log2_len;
  endfunction

endpackage

// File: rtl/sc_load_down_counter.sv
// Loadable down-counter used by the job sequencer to time WARMUP and RUN.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (value -> 0)
//   load       : load load_value (has priority over dec)
//   load_value : value loaded on load
//   dec        : decrement by one; holds at zero rather than wrapping
//   value      : current count
//   zero       : value == 0
module sc_load_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      value <= '0;
    else if (load)
      value <= load_value;
    else if (dec && !zero)
      value <= value - W'(1);
  end

  assign zero = (value == '0);

endmodule

// File: rtl/sc_mm_controller.sv
// Job sequencer for the stochastic matrix-multiply datapath (SNG banks,
// sc_matrix_mult, SD converter bank). One job: capture operands and clear
// SNGs/SD converters (LOAD), discard MM_LATENCY cycles of pipeline fill
// (WARMUP), let the SD converters count for exactly 2^STREAM_LEN_LOG2 cycles
// (RUN), then hold the result valid until acknowledged (DONE).
//
// Parameters:
//   STREAM_LEN_LOG2 : stream length is 2^STREAM_LEN_LOG2 cycles (>= 1)
//   MM_LATENCY      : multiply pipeline latency, 0 .. 2^STREAM_LEN_LOG2-1
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : job request, taken when start && start_ready
//   start_ready  : high only in IDLE
//   abort        : synchronous abort back to IDLE, highest priority
//   operand_load : one-cycle pulse, upstream latches operand matrices
//   sng_clear    : SNG seed reload
//   sd_clear     : SD converter counter clear
//   sd_count_en  : SD converters accumulate while high
//   sd_last      : final counting cycle
//   out_valid    : result valid, held until out_ack
//   out_ack      : consumer accepted the result
//   busy         : not IDLE
//
// Optional feature (macro SC_MM_CTRL_PERF_EN): adds saturating outputs
//   job_count   : completed handshakes (out_valid && out_ack)
//   abort_count : aborts taken outside IDLE
//
// All strobes are decoded from registered state and counter, so there is no
// combinational path from any input to any output.
module sc_mm_controller
  import sc_mm_pkg::*;
#(
  parameter int STREAM_LEN_LOG2 = 8,
  parameter int MM_LATENCY      = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic start_ready,
  input  logic abort,
  output logic operand_load,
  output logic sng_clear,
  output logic sd_clear,
  output logic sd_count_en,
  output logic sd_last,
  output logic out_valid,
  input  logic out_ack,
  output logic busy
`ifdef SC_MM_CTRL_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] job_count,
  output logic [PERF_CNT_W-1:0] abort_count
`endif
);

  localparam int CW = STREAM_LEN_LOG2;
  // RUN starts at 2^L-1 and counts down to 0, giving exactly 2^L cycles.
  localparam logic [CW-1:0] RUN_LOAD = CW'(stream_len(CW) - 1);
  localparam logic [CW-1:0] LAT_LOAD = CW'(MM_LATENCY);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          cnt_zero;
  logic          cnt_is_one;
  logic          cnt_load;
  logic [CW-1:0] cnt_value;
  logic          cnt_dec;

  assign cnt_is_one = (cnt == CW'(1));

  // Counter control. Every state entry reloads the counter, so it never has
  // to wrap. LOAD goes straight to the RUN length when there is no latency.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_value = '0;
    cnt_dec   = 1'b0;
    if (abort && state != IDLE) begin
      cnt_load = 1'b1;
    end else begin
      case (state)
        LOAD: begin
          cnt_load  = 1'b1;
          cnt_value = (MM_LATENCY > 0) ? LAT_LOAD : RUN_LOAD;
        end
        WARMUP: begin
          if (cnt_is_one) begin
            cnt_load  = 1'b1;
            cnt_value = RUN_LOAD;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        RUN:     cnt_dec = 1'b1;
        default: ;
      endcase
    end
  end

  sc_load_down_counter #(.W(CW)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_value (cnt_value),
    .dec        (cnt_dec),
    .value      (cnt),
    .zero       (cnt_zero)
  );

  // Abort wins over start, out_ack and every timed transition; in IDLE it
  // simply keeps the machine idle, which also drops a coincident start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= LOAD;
        LOAD:    state <= (MM_LATENCY > 0) ? WARMUP : RUN;
        WARMUP:  if (cnt_is_one) state <= RUN;
        RUN:     if (cnt_zero) state <= DONE;
        DONE:    if (out_ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode of the registered state.
  always_comb begin
    start_ready  = (state == IDLE);
    operand_load = (state == LOAD);
    sng_clear    = (state == LOAD);
    // WARMUP keeps the SD counters cleared so pipeline garbage is dropped.
    sd_clear     = (state == LOAD) || (state == WARMUP);
    sd_count_en  = (state == RUN);
    sd_last      = (state == RUN) && cnt_zero;
    out_valid    = (state == DONE);
    busy         = (state != IDLE);
  end

`ifdef SC_MM_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_count   <= '0;
      abort_count <= '0;
    end else begin
      if (out_valid && out_ack && job_count != '1)
        job_count <= job_count + PERF_CNT_W'(1);
      if (abort && state != IDLE && abort_count != '1)
        abort_count <= abort_count + PERF_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sc_mm_controller.sv
// Directed bench for sc_mm_controller (L=3). Expected per-cycle output
// vectors are queued when a job is launched and popped one per cycle.
module tb_sc_mm_controller;

  // {start_ready, operand_load, sng_clear, sd_clear, sd_count_en, sd_last, out_valid, busy}
  localparam logic [7:0] V_IDLE = 8'b1000_0000;
  localparam logic [7:0] V_LOAD = 8'b0111_0001;
  localparam logic [7:0] V_WARM = 8'b0001_0001;
  localparam logic [7:0] V_RUN  = 8'b0000_1001;
  localparam logic [7:0] V_LAST = 8'b0000_1101;
  localparam logic [7:0] V_DONE = 8'b0000_0011;

  logic clk = 1'b0;
  logic rst, start, abort, out_ack, start0, abort0, ack0;
  logic start_ready, operand_load, sng_clear, sd_clear, sd_count_en, sd_last, out_valid, busy;
  logic start_ready0, operand_load0, sng_clear0, sd_clear0, sd_count_en0, sd_last0, out_valid0, busy0;
`ifdef SC_MM_CTRL_PERF_EN
  logic [31:0] job_count, abort_count, job_count0, abort_count0;
`endif

  int checks = 0;
  int errors = 0;
  int exp_jobs = 0;
  int exp_aborts = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  sc_mm_controller #(.STREAM_LEN_LOG2(3), .MM_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready), .abort(abort),
    .operand_load(operand_load), .sng_clear(sng_clear), .sd_clear(sd_clear),
    .sd_count_en(sd_count_en), .sd_last(sd_last), .out_valid(out_valid),
    .out_ack(out_ack), .busy(busy)
`ifdef SC_MM_CTRL_PERF_EN
    , .job_count(job_count), .abort_count(abort_count)
`endif
  );

  sc_mm_controller #(.STREAM_LEN_LOG2(3), .MM_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .start_ready(start_ready0), .abort(abort0),
    .operand_load(operand_load0), .sng_clear(sng_clear0), .sd_clear(sd_clear0),
    .sd_count_en(sd_count_en0), .sd_last(sd_last0), .out_valid(out_valid0),
    .out_ack(ack0), .busy(busy0)
`ifdef SC_MM_CTRL_PERF_EN
    , .job_count(job_count0), .abort_count(abort_count0)
`endif
  );

  function automatic logic [7:0] vec(input bit sel);
    if (sel)
      return {start_ready0, operand_load0, sng_clear0, sd_clear0, sd_count_en0, sd_last0, out_valid0, busy0};
    return {start_ready, operand_load, sng_clear, sd_clear, sd_count_en, sd_last, out_valid, busy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs for cycles 1.. of a job started at edge 0, ending in DONE.
  task automatic push_job(input int lat);
    q.push_back(V_LOAD);
    for (int i = 0; i < lat; i++) q.push_back(V_WARM);
    for (int i = 0; i < 7; i++) q.push_back(V_RUN);
    q.push_back(V_LAST);
    q.push_back(V_DONE);
  endtask

  // Advance one clock, sample 1 time unit after the edge, compare with queue head.
  task automatic step(input bit sel, input string tag);
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk(tag, {24'd0, vec(sel)}, {24'd0, e});
    end
  endtask

  task automatic idle_steps(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      q.push_back(V_IDLE);
      step(0, tag);
    end
  endtask

  task automatic chk_perf(input string tag);
`ifdef SC_MM_CTRL_PERF_EN
    chk({tag, "_job_count"}, job_count, exp_jobs);
    chk({tag, "_abort_count"}, abort_count, exp_aborts);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ack = 1'b0;
    start0 = 1'b0; abort0 = 1'b0; ack0 = 1'b0;

    // Reset state
    #2;
    chk("reset_vec", {24'd0, vec(0)}, {24'd0, V_IDLE});
    chk("reset_vec0", {24'd0, vec(1)}, {24'd0, V_IDLE});
    @(posedge clk); #3;
    rst = 1'b0;
    chk_perf("reset");
    idle_steps(2, "idle_after_reset");

    // Basic job, MM_LATENCY=2: LOAD c1, WARMUP c2-3, RUN c4-11, last c11, DONE c12
    push_job(2);
    start = 1'b1; step(0, "job1");
    start = 1'b0;
    repeat (11) step(0, "job1");
    out_ack = 1'b1; q.push_back(V_IDLE); step(0, "job1_ack");
    out_ack = 1'b0; exp_jobs++;
    chk_perf("job1");

    // MM_LATENCY=0: RUN c2-9, DONE c10, no WARMUP
    push_job(0);
    start0 = 1'b1; step(1, "lat0");
    start0 = 1'b0;
    repeat (9) step(1, "lat0");
    ack0 = 1'b1; q.push_back(V_IDLE); step(1, "lat0_ack");
    ack0 = 1'b0;

    // Ack withheld 20 cycles with start pulsing; ack in cycle 32 -> IDLE at 33
    push_job(2);
    start = 1'b1; step(0, "hold");
    start = 1'b0;
    repeat (11) step(0, "hold");
    for (int i = 13; i <= 32; i++) begin
      start = i[0];
      q.push_back(V_DONE);
      step(0, "hold_done");
    end
    start = 1'b0; out_ack = 1'b1;
    q.push_back(V_IDLE); step(0, "hold_ack");
    out_ack = 1'b0; exp_jobs++;
    chk("hold_start_ready", {31'd0, start_ready}, 32'd1);
    chk_perf("hold");

    // Abort in 3rd RUN cycle (c6), out_ack high in WARMUP/RUN must be ignored
    push_job(2);
    start = 1'b1; step(0, "abort_run");
    start = 1'b0; out_ack = 1'b1;
    repeat (5) step(0, "abort_run");
    q.delete();
    out_ack = 1'b0; abort = 1'b1;
    q.push_back(V_IDLE); step(0, "abort_next");
    abort = 1'b0; exp_aborts++;
    idle_steps(12, "abort_quiet");
    chk_perf("abort_run");

    // Abort in IDLE: no effect, not counted. Start+abort in IDLE: start dropped.
    abort = 1'b1; idle_steps(1, "abort_idle");
    start = 1'b1; idle_steps(1, "start_abort");
    start = 1'b0; abort = 1'b0;
    idle_steps(2, "start_abort_after");
    chk_perf("abort_idle");

    // Abort together with out_ack in DONE
    push_job(2);
    start = 1'b1; step(0, "abort_ack");
    start = 1'b0;
    repeat (11) step(0, "abort_ack");
    abort = 1'b1; out_ack = 1'b1;
    q.push_back(V_IDLE); step(0, "abort_ack_next");
    abort = 1'b0; out_ack = 1'b0;
    exp_jobs++; exp_aborts++;
    idle_steps(1, "abort_ack_idle");
    chk_perf("abort_ack");

    // Asynchronous reset mid-WARMUP
    push_job(2);
    start = 1'b1; step(0, "async_rst");
    start = 1'b0; step(0, "async_rst");
    q.delete();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_vec", {24'd0, vec(0)}, {24'd0, V_IDLE});
    exp_jobs = 0; exp_aborts = 0;
    chk_perf("async_rst");
    #2 rst = 1'b0;
    push_job(2);
    start = 1'b1; step(0, "post_rst_job");
    start = 1'b0;
    repeat (11) step(0, "post_rst_job");
    out_ack = 1'b1; q.push_back(V_IDLE); step(0, "post_rst_ack");
    out_ack = 1'b0; exp_jobs++;
    chk_perf("post_rst");

    // Back-to-back with start held high: ack c12, second LOAD c14
    push_job(2);
    start = 1'b1; step(0, "b2b_1");
    repeat (11) step(0, "b2b_1");
    out_ack = 1'b1; q.push_back(V_IDLE); step(0, "b2b_gap");
    out_ack = 1'b0; exp_jobs++;
    push_job(2);
    step(0, "b2b_2");
    start = 1'b0;
    repeat (11) step(0, "b2b_2");
    out_ack = 1'b1; q.push_back(V_IDLE); step(0, "b2b_ack");
    out_ack = 1'b0; exp_jobs++;
    chk_perf("b2b");

    chk("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
